// File: rtl/scan_sequencer_pkg.sv
// scan_pkg: shared constants and state encoding for the channel-scan sequencer.
//   NUM_CH    number of decoder channels
//   SEL_W     width of the channel select
//   DWELL_MIN smallest dwell actually used (a programmed 0 becomes this)
//   state_t   sequencer states
package scan_pkg;

  localparam int unsigned NUM_CH    = 8;
  localparam int unsigned SEL_W     = 3;
  localparam int unsigned DWELL_MIN = 1;

  typedef enum logic {
    S_IDLE  = 1'b0,
    S_DWELL = 1'b1
  } state_t;

endpackage

// File: rtl/scan_sequencer_next_chan_finder.sv
// next_chan_finder: combinational channel search over an enable mask.
//   mask    [NUM_CH-1:0] in   channel enables
//   cur     [SEL_W-1:0]  in   currently selected channel
//   nxt     [SEL_W-1:0]  out  lowest set bit strictly above cur
//   nxt_vld              out  nxt is valid (some bit above cur is set)
//   first   [SEL_W-1:0]  out  lowest set bit
//   any                  out  mask is nonzero
module next_chan_finder
  import scan_pkg::*;
(
  input  logic [NUM_CH-1:0] mask,
  input  logic [SEL_W-1:0]  cur,
  output logic [SEL_W-1:0]  nxt,
  output logic              nxt_vld,
  output logic [SEL_W-1:0]  first,
  output logic              any
);

  always_comb begin
    nxt     = '0;
    nxt_vld = 1'b0;
    first   = '0;
    any     = |mask;
    // Walk from the top channel down so the last hit is the lowest one.
    for (int unsigned k = 0; k < NUM_CH; k++) begin
      if (mask[NUM_CH-1-k]) begin
        first = SEL_W'(NUM_CH-1-k);
        if (SEL_W'(NUM_CH-1-k) > cur) begin
          nxt     = SEL_W'(NUM_CH-1-k);
          nxt_vld = 1'b1;
        end
      end
    end
  end

endmodule

// File: rtl/scan_sequencer.sv
// scan_sequencer: steps the downstream 3-to-8 decoder through the channels
// enabled in a mask, lowest to highest, holding each for a dwell time.
//   clk    in   clock, rising edge
//   rst    in   synchronous active-high reset
//   start  in   begin a scan (accepted only in IDLE, and not with stop)
//   stop   in   abort; IDLE on the next edge with no done/wrap
//   mask   in   channel enables, latched on accepted start
//   dwell  in   cycles per channel, latched on accepted start (0 acts as 1)
//   mode   in   0 one-shot, 1 continuous, latched on accepted start
//   sel    out  channel index to decoder in
//   en     out  decoder enable, high while a channel is driven
//   busy   out  high in DWELL
//   done   out  pulse on natural one-shot completion (or zero-mask start)
//   wrap   out  pulse at the end of every completed pass
module scan_sequencer
  import scan_pkg::*;
#(
  parameter int unsigned DWELL_W = 8
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic               stop,
  input  logic [NUM_CH-1:0]  mask,
  input  logic [DWELL_W-1:0] dwell,
  input  logic               mode,
  output logic [SEL_W-1:0]   sel,
  output logic               en,
  output logic               busy,
  output logic               done,
  output logic               wrap
);

  state_t             state_q, state_d;
  logic [DWELL_W-1:0] cnt_q, cnt_d;
  logic [NUM_CH-1:0]  mask_q, mask_d;
  logic [DWELL_W-1:0] dwell_q, dwell_d;
  logic               mode_q, mode_d;
  logic [SEL_W-1:0]   sel_q, sel_d;
  logic               en_q, en_d;
  logic               busy_q, busy_d;
  logic               done_q, done_d;
  logic               wrap_q, wrap_d;

  logic               done_ev, wrap_ev;
  logic [DWELL_W-1:0] dwell_eff;
  logic [NUM_CH-1:0]  find_mask;
  logic [SEL_W-1:0]   f_nxt, f_first;
  logic               f_nxt_vld, f_any;

  assign dwell_eff = (dwell < DWELL_W'(DWELL_MIN)) ? DWELL_W'(DWELL_MIN) : dwell;

  // In IDLE the search must see the incoming mask so the first channel is
  // driven on the very next cycle; once scanning, only the latched copy.
  assign find_mask = (state_q == S_IDLE) ? mask : mask_q;

  next_chan_finder u_finder (
    .mask    (find_mask),
    .cur     (sel_q),
    .nxt     (f_nxt),
    .nxt_vld (f_nxt_vld),
    .first   (f_first),
    .any     (f_any)
  );

  // State register and all flops.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      mask_q  <= '0;
      dwell_q <= '0;
      mode_q  <= 1'b0;
      sel_q   <= '0;
      en_q    <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      wrap_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      mask_q  <= mask_d;
      dwell_q <= dwell_d;
      mode_q  <= mode_d;
      sel_q   <= sel_d;
      en_q    <= en_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      wrap_q  <= wrap_d;
    end
  end

  // Next-state logic: state, counter, config, channel and completion events.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    mask_d  = mask_q;
    dwell_d = dwell_q;
    mode_d  = mode_q;
    sel_d   = sel_q;
    done_ev = 1'b0;
    wrap_ev = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        if (start && !stop) begin
          mask_d  = mask;
          dwell_d = dwell_eff;
          mode_d  = mode;
          if (f_any) begin
            state_d = S_DWELL;
            sel_d   = f_first;
            cnt_d   = dwell_eff - 1'b1;
          end else begin
            done_ev = 1'b1;
          end
        end
      end
      S_DWELL: begin
        if (stop) begin
          state_d = S_IDLE;
        end else if (cnt_q != '0) begin
          cnt_d = cnt_q - 1'b1;
        end else if (f_nxt_vld) begin
          sel_d = f_nxt;
          cnt_d = dwell_q - 1'b1;
        end else begin
          wrap_ev = 1'b1;
          if (mode_q) begin
            sel_d = f_first;
            cnt_d = dwell_q - 1'b1;
          end else begin
            state_d = S_IDLE;
            done_ev = 1'b1;
          end
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Output logic: registered outputs derived from the next state and events.
  always_comb begin
    en_d   = (state_d == S_DWELL);
    busy_d = (state_d == S_DWELL);
    done_d = done_ev;
    wrap_d = wrap_ev;
  end

  assign sel  = sel_q;
  assign en   = en_q;
  assign busy = busy_q;
  assign done = done_q;
  assign wrap = wrap_q;

endmodule

// File: tb/tb_scan_sequencer.sv
module tb_scan_sequencer;

  logic       clk = 1'b0;
  logic       rst, start, stop, mode;
  logic [7:0] mask, dwell;
  logic [2:0] sel;
  logic       en, busy, done, wrap;

  logic [7:0] nf_mask;
  logic [2:0] nf_cur, nf_nxt, nf_first;
  logic       nf_vld, nf_any;

  int n_checks = 0;
  int n_pass   = 0;

  always #5 clk = ~clk;

  scan_sequencer #(.DWELL_W(8)) dut (
    .clk   (clk),
    .rst   (rst),
    .start (start),
    .stop  (stop),
    .mask  (mask),
    .dwell (dwell),
    .mode  (mode),
    .sel   (sel),
    .en    (en),
    .busy  (busy),
    .done  (done),
    .wrap  (wrap)
  );

  next_chan_finder u_nf (
    .mask    (nf_mask),
    .cur     (nf_cur),
    .nxt     (nf_nxt),
    .nxt_vld (nf_vld),
    .first   (nf_first),
    .any     (nf_any)
  );

  typedef struct {
    logic       rst, start, stop;
    logic [7:0] mask, dwell;
    logic       mode;
    logic [2:0] sel;
    logic       en, busy, done, wrap;
  } vec_t;

  vec_t vecs[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
  endtask

  task automatic row(input logic r, input logic s, input logic p, input logic [7:0] m,
                     input logic [7:0] d, input logic md, input logic [2:0] es,
                     input logic ee, input logic eb, input logic ed, input logic ew);
    vec_t v;
    v.rst = r; v.start = s; v.stop = p; v.mask = m; v.dwell = d; v.mode = md;
    v.sel = es; v.en = ee; v.busy = eb; v.done = ed; v.wrap = ew;
    vecs.push_back(v);
  endtask

  // mask 1010_0101, dwell 2, one-shot: channels 0,2,5,7 for two cycles each.
  task automatic test1_rows();
    logic [2:0] seq [8];
    seq = '{3'd0, 3'd0, 3'd2, 3'd2, 3'd5, 3'd5, 3'd7, 3'd7};
    row(0, 1, 0, 8'hA5, 8'd2, 0, seq[0], 1, 1, 0, 0);
    for (int i = 1; i < 8; i++) row(0, 0, 0, 8'h00, 8'd0, 0, seq[i], 1, 1, 0, 0);
    row(0, 0, 0, 8'h00, 8'd0, 0, 3'd7, 0, 0, 1, 1);
    row(0, 0, 0, 8'h00, 8'd0, 0, 3'd7, 0, 0, 0, 0);
  endtask

  initial begin
    logic [2:0] m_nxt, m_first;
    logic       m_vld, m_any;
    int         c, en_cnt, done_c;
    logic       wrap_seen;
    logic [2:0] s255, s256;

    rst = 1'b1; start = 0; stop = 0; mode = 0; mask = '0; dwell = '0;
    nf_mask = '0; nf_cur = '0;

    // Standalone exhaustive check of the channel finder.
    for (int m = 0; m < 256; m++) begin
      for (int cu = 0; cu < 8; cu++) begin
        nf_mask = 8'(m); nf_cur = 3'(cu);
        #1;
        m_vld = 0; m_nxt = 0; m_any = (m != 0); m_first = 0;
        for (int j = 7; j >= 0; j--) if (nf_mask[j]) m_first = 3'(j);
        for (int j = cu + 1; j < 8 && !m_vld; j++)
          if (nf_mask[j]) begin m_nxt = 3'(j); m_vld = 1; end
        check($sformatf("finder m=%0h cur=%0d", m, cu),
              {nf_nxt, nf_vld, nf_first, nf_any}, {m_nxt, m_vld, m_first, m_any});
      end
    end

    @(posedge clk); #1;
    check("reset_state", {sel, en, busy, done, wrap}, 7'b000_0000);
    rst = 1'b0;

    // Test 1
    test1_rows();
    // Test 2: all channels, dwell 0 treated as 1
    row(0, 1, 0, 8'hFF, 8'd0, 0, 3'd0, 1, 1, 0, 0);
    for (int i = 1; i < 8; i++) row(0, 0, 0, 8'h00, 8'd0, 0, 3'(i), 1, 1, 0, 0);
    row(0, 0, 0, 8'h00, 8'd0, 0, 3'd7, 0, 0, 1, 1);
    // Test 3: started in the done cycle; continuous 0,7 alternation, stop at edge 6
    row(0, 1, 0, 8'h81, 8'd1, 1, 3'd0, 1, 1, 0, 0);
    row(0, 0, 0, 8'h00, 8'd0, 0, 3'd7, 1, 1, 0, 0);
    row(0, 0, 0, 8'h00, 8'd0, 0, 3'd0, 1, 1, 0, 1);
    row(0, 0, 0, 8'h00, 8'd0, 0, 3'd7, 1, 1, 0, 0);
    row(0, 0, 0, 8'h00, 8'd0, 0, 3'd0, 1, 1, 0, 1);
    row(0, 0, 0, 8'h00, 8'd0, 0, 3'd7, 1, 1, 0, 0);
    row(0, 0, 1, 8'h00, 8'd0, 0, 3'd7, 0, 0, 0, 0);
    row(0, 0, 0, 8'h00, 8'd0, 0, 3'd7, 0, 0, 0, 0);
    // Test 4: zero mask
    row(0, 1, 0, 8'h00, 8'd3, 0, 3'd7, 0, 0, 1, 0);
    row(0, 0, 0, 8'h00, 8'd0, 0, 3'd7, 0, 0, 0, 0);
    // Test 5: start with stop in IDLE
    row(0, 1, 1, 8'hFF, 8'd4, 0, 3'd7, 0, 0, 0, 0);
    row(0, 0, 0, 8'hFF, 8'd4, 0, 3'd7, 0, 0, 0, 0);
    // Single channel, continuous, dwell 3: wrap every 3 cycles
    row(0, 1, 0, 8'h10, 8'd3, 1, 3'd4, 1, 1, 0, 0);
    row(0, 0, 0, 8'h00, 8'd0, 0, 3'd4, 1, 1, 0, 0);
    row(0, 0, 0, 8'h00, 8'd0, 0, 3'd4, 1, 1, 0, 0);
    row(0, 0, 0, 8'h00, 8'd0, 0, 3'd4, 1, 1, 0, 1);
    row(0, 0, 0, 8'h00, 8'd0, 0, 3'd4, 1, 1, 0, 0);
    row(0, 0, 0, 8'h00, 8'd0, 0, 3'd4, 1, 1, 0, 0);
    row(0, 0, 0, 8'h00, 8'd0, 0, 3'd4, 1, 1, 0, 1);
    row(0, 0, 1, 8'h00, 8'd0, 0, 3'd4, 0, 0, 0, 0);
    // Test 6: config churn and second start while busy leave test 1 intact
    row(0, 1, 0, 8'hA5, 8'd2, 0, 3'd0, 1, 1, 0, 0);
    row(0, 0, 0, 8'hFF, 8'd5, 1, 3'd0, 1, 1, 0, 0);
    row(0, 1, 0, 8'hFF, 8'd5, 1, 3'd2, 1, 1, 0, 0);
    row(0, 0, 0, 8'h01, 8'd0, 1, 3'd2, 1, 1, 0, 0);
    row(0, 1, 0, 8'h02, 8'd9, 1, 3'd5, 1, 1, 0, 0);
    row(0, 0, 0, 8'hFF, 8'd5, 1, 3'd5, 1, 1, 0, 0);
    row(0, 0, 0, 8'hFF, 8'd5, 1, 3'd7, 1, 1, 0, 0);
    row(0, 0, 0, 8'hFF, 8'd5, 1, 3'd7, 1, 1, 0, 0);
    row(0, 0, 0, 8'hFF, 8'd5, 1, 3'd7, 0, 0, 1, 1);
    row(0, 0, 0, 8'hFF, 8'd5, 1, 3'd7, 0, 0, 0, 0);
    // Test 7: reset during cycle 4 of test 1, then a fresh run
    row(0, 1, 0, 8'hA5, 8'd2, 0, 3'd0, 1, 1, 0, 0);
    row(0, 0, 0, 8'h00, 8'd0, 0, 3'd0, 1, 1, 0, 0);
    row(0, 0, 0, 8'h00, 8'd0, 0, 3'd2, 1, 1, 0, 0);
    row(0, 0, 0, 8'h00, 8'd0, 0, 3'd2, 1, 1, 0, 0);
    row(1, 1, 0, 8'hA5, 8'd2, 0, 3'd0, 0, 0, 0, 0);
    test1_rows();

    for (int i = 0; i < vecs.size(); i++) begin
      rst = vecs[i].rst; start = vecs[i].start; stop = vecs[i].stop;
      mask = vecs[i].mask; dwell = vecs[i].dwell; mode = vecs[i].mode;
      @(posedge clk); #1;
      check($sformatf("vec%0d {sel,en,busy,done,wrap}", i),
            {sel, en, busy, done, wrap},
            {vecs[i].sel, vecs[i].en, vecs[i].busy, vecs[i].done, vecs[i].wrap});
    end
    rst = 0; start = 0; stop = 0;

    // Maximum dwell: two channels at 255 cycles each, one-shot.
    start = 1; mask = 8'h81; dwell = 8'd255; mode = 0;
    @(posedge clk); #1;
    start = 0;
    c = 1; en_cnt = 0; done_c = 0; wrap_seen = 0; s255 = '0; s256 = '0;
    while (c <= 2000 && done_c == 0) begin
      if (en) en_cnt++;
      if (c == 255) s255 = sel;
      if (c == 256) s256 = sel;
      if (done) begin
        done_c = c;
        wrap_seen = wrap;
      end else begin
        @(posedge clk); #1;
        c++;
      end
    end
    check("maxdwell en_cycles", en_cnt, 510);
    check("maxdwell done_cycle", done_c, 511);
    check("maxdwell wrap_with_done", wrap_seen, 1);
    check("maxdwell sel@255", s255, 0);
    check("maxdwell sel@256", s256, 7);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
